bus_arbiter_4: RTL and testbench

Four-requester round-robin arbiter that generates the `Sel` and `Enable` controls for the four-input bus multiplexer in the MCU bus fabric. It sits directly upstream of that multiplexer and decides which of four bus masters currently drives the shared bus. Grants are registered, one-hot, and held until the owner ends its transfer or withdraws its request. An optional beat limit forces the owner to give up the bus.

---
 rtl/bus_arbiter_4.sv | 156 +++++++++++++++
 tb/tb_bus_arbiter_4.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4: four-requester round-robin bus arbiter.
// Drives the Sel/Enable controls of the downstream four-input bus multiplexer.
// Grants are registered and one-hot, and they are held until the owner asserts
// Last or drops its request.
// Optional feature macro: BUS_ARBITER_4_HOLD_LIMIT_EN. When it is defined, the
// arbiter forces a release after HoldMax consecutive owned cycles and pulses
// Preempt.
module bus_arbiter_4 #(
  parameter int HoldMax = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Req,
  input  logic       Last,
  output logic [3:0] Grant,
  output logic [1:0] Sel,
  output logic       Enable,
  output logic       Preempt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Beat value at which the current owner has used its HoldMax cycles.
  localparam logic [7:0] LIMIT = 8'(HoldMax - 1);

  state_t     state_r;
  logic [1:0] ptr_r;
  logic [1:0] owner_r;
  logic [7:0] beat_r;

  logic       limit_s;
  logic       quit_s;
  logic       release_s;
  logic       forced_s;
  logic [3:0] cand_s;
  logic [1:0] start_s;
  logic [2:0] pick_s;

  // Circular first-set search over req, starting at index start.
  // The result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    // Walk from the farthest offset down to the nearest, so the nearest hit wins.
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

`ifdef BUS_ARBITER_4_HOLD_LIMIT_EN
  assign limit_s = (state_r == OWNED) && (beat_r == LIMIT);
`else
  // No beat limit in this build, so HoldMax has no effect on behaviour.
  assign limit_s = (beat_r == LIMIT) & 1'b0;
`endif

  // Release detection and next-owner candidate selection for the current state.
  always_comb begin
    quit_s    = 1'b0;
    release_s = 1'b0;
    forced_s  = 1'b0;
    cand_s    = Req;
    start_s   = ptr_r;
    if (state_r == OWNED) begin
      quit_s    = Last | ~Req[owner_r];
      release_s = quit_s | limit_s;
      forced_s  = limit_s & ~quit_s;
      cand_s    = Req & ~(4'b0001 << owner_r);
      start_s   = owner_r + 2'd1;
    end else begin
      quit_s    = 1'b0;
      release_s = 1'b0;
      forced_s  = 1'b0;
      cand_s    = Req;
      start_s   = ptr_r;
    end
    pick_s = rr_pick(cand_s, start_s);
  end

  // Arbitration FSM: registered state, pointer, beat counter and all outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      owner_r <= 2'd0;
      beat_r  <= 8'd0;
      Grant   <= 4'b0000;
      Sel     <= 2'd0;
      Enable  <= 1'b0;
      Preempt <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          Preempt <= 1'b0;
          if (pick_s[2]) begin
            state_r <= OWNED;
            owner_r <= pick_s[1:0];
            beat_r  <= 8'd0;
            Grant   <= 4'b0001 << pick_s[1:0];
            Sel     <= pick_s[1:0];
            Enable  <= 1'b1;
          end else begin
            // Sel keeps the last owner while the bus is idle.
            Grant   <= 4'b0000;
            Enable  <= 1'b0;
          end
        end
        OWNED: begin
          Preempt <= forced_s;
          if (beat_r != 8'd255) begin
            beat_r <= beat_r + 8'd1;
          end else begin
            beat_r <= beat_r;
          end
          if (release_s) begin
            ptr_r <= owner_r + 2'd1;
            if (pick_s[2]) begin
              // Back-to-back handover with no idle cycle in between.
              owner_r <= pick_s[1:0];
              beat_r  <= 8'd0;
              Grant   <= 4'b0001 << pick_s[1:0];
              Sel     <= pick_s[1:0];
              Enable  <= 1'b1;
            end else begin
              // No other requester: go idle even if the old owner still requests.
              state_r <= IDLE;
              Grant   <= 4'b0000;
              Enable  <= 1'b0;
            end
          end else begin
            Grant  <= 4'b0001 << owner_r;
            Sel    <= owner_r;
            Enable <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          Grant   <= 4'b0000;
          Enable  <= 1'b0;
          Preempt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// tb_bus_arbiter_4: directed self-checking bench for bus_arbiter_4.
// When BUS_ARBITER_4_HOLD_LIMIT_EN is defined, the hold-limit steps expect
// preemption after HoldMax = 4 cycles.
module tb_bus_arbiter_4;

  logic       Clock;
  logic       Reset;
  logic [3:0] Req;
  logic       Last;
  logic [3:0] Grant;
  logic [1:0] Sel;
  logic       Enable;
  logic       Preempt;

  int passed = 0;
  int total  = 0;
  int exp_owner [5] = '{0, 1, 2, 3, 0};
  logic [3:0] one_hot;

  bus_arbiter_4 #(.HoldMax(4)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req     (Req),
    .Last    (Last),
    .Grant   (Grant),
    .Sel     (Sel),
    .Enable  (Enable),
    .Preempt (Preempt)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_owner(input string tag, input int idx);
    one_hot = 4'b0001 << idx;
    check({tag, "_grant"}, {4'h0, Grant}, {4'h0, one_hot});
    check({tag, "_sel"}, {6'h00, Sel}, 8'(idx));
    check({tag, "_en"}, {7'h00, Enable}, 8'h01);
  endtask

  initial begin
    Reset = 1'b1;
    Req   = 4'b0000;
    Last  = 1'b0;
    #12;
    check("rst_grant", {4'h0, Grant}, 8'h00);
    check("rst_sel", {6'h00, Sel}, 8'h00);
    check("rst_en", {7'h00, Enable}, 8'h00);
    check("rst_preempt", {7'h00, Preempt}, 8'h00);
    Reset = 1'b0;

    // Single request from IDLE, then Last with the request withdrawn.
    Req = 4'b0100;
    step();
    check_owner("single", 2);
    Last = 1'b1;
    Req  = 4'b0000;
    step();
    check("single_idle_grant", {4'h0, Grant}, 8'h00);
    check("single_idle_en", {7'h00, Enable}, 8'h00);
    check("single_idle_sel", {6'h00, Sel}, 8'h02);
    Last = 1'b0;

    // Reset pulse between clock edges while master 2 owns the bus.
    Req = 4'b0100;
    step();
    check_owner("pre_rst", 2);
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_grant", {4'h0, Grant}, 8'h00);
    check("midrst_sel", {6'h00, Sel}, 8'h00);
    check("midrst_en", {7'h00, Enable}, 8'h00);
    #1;
    Reset = 1'b0;
    Req   = 4'b0000;

    // Round robin. Ptr must be 0 after the reset, so master 0 wins first.
    Req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      check_owner("rr_first", exp_owner[i]);
      Last = 1'b0;
      step();
      check_owner("rr_second", exp_owner[i]);
      Last = 1'b1;
      step();
    end
    check_owner("rr_after", 1);
    Last = 1'b0;

    // Master 1 drops its request while only master 3 is requesting.
    Req = 4'b1000;
    step();
    check_owner("drop", 3);
    Req = 4'b0000;
    step();
    check("drop_idle_en", {7'h00, Enable}, 8'h00);

    // Hold limit: master 0 requests continuously alongside master 1.
    Req = 4'b0011;
    step();
    check_owner("hold_c1", 0);
`ifdef BUS_ARBITER_4_HOLD_LIMIT_EN
    for (int k = 2; k <= 4; k++) begin
      step();
      check_owner("hold_keep", 0);
      check("hold_keep_preempt", {7'h00, Preempt}, 8'h00);
    end
    step();
    check_owner("hold_handover", 1);
    check("hold_preempt_pulse", {7'h00, Preempt}, 8'h01);
    step();
    check_owner("hold_after", 1);
    check("hold_preempt_end", {7'h00, Preempt}, 8'h00);
`else
    for (int k = 2; k <= 7; k++) begin
      step();
      check_owner("hold_keep", 0);
      check("hold_keep_preempt", {7'h00, Preempt}, 8'h00);
    end
`endif
    Req = 4'b0000;
    step();
    check("hold_idle_en", {7'h00, Enable}, 8'h00);

    // Simultaneous release on the fourth owned cycle: Last, a dropped request
    // and (when compiled in) the limit together. Ptr ends at 3.
    Req = 4'b0101;
    step();
    check_owner("simul_c1", 2);
    step();
    step();
    step();
    check_owner("simul_c4", 2);
    Last = 1'b1;
    Req  = 4'b0000;
    step();
    check("simul_grant", {4'h0, Grant}, 8'h00);
    check("simul_en", {7'h00, Enable}, 8'h00);
    check("simul_preempt", {7'h00, Preempt}, 8'h00);
    Last = 1'b0;
    Req  = 4'b1111;
    step();
    check_owner("simul_ptr", 3);
    check("simul_preempt2", {7'h00, Preempt}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
